// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, functs, ALU operations,
// FSM states and datapath mux selects.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef logic [3:0] alu_op_t;
  localparam alu_op_t ALU_ADDU = 4'd0;
  localparam alu_op_t ALU_SUBU = 4'd1;
  localparam alu_op_t ALU_AND  = 4'd2;
  localparam alu_op_t ALU_OR   = 4'd3;
  localparam alu_op_t ALU_XOR  = 4'd4;
  localparam alu_op_t ALU_NOR  = 4'd5;
  localparam alu_op_t ALU_SLT  = 4'd6;
  localparam alu_op_t ALU_SLTU = 4'd7;
  localparam alu_op_t ALU_SLL  = 4'd8;
  localparam alu_op_t ALU_SRL  = 4'd9;
  localparam alu_op_t ALU_SRA  = 4'd10;
  localparam alu_op_t ALU_LUI  = 4'd11;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StTrap
  } state_e;

  localparam logic [1:0] PC_SRC_SEQ = 2'd0;
  localparam logic [1:0] PC_SRC_BR  = 2'd1;
  localparam logic [1:0] PC_SRC_JMP = 2'd2;
  localparam logic [1:0] PC_SRC_JR  = 2'd3;

  localparam logic [1:0] REG_DST_RT = 2'd0;
  localparam logic [1:0] REG_DST_RD = 2'd1;
  localparam logic [1:0] REG_DST_RA = 2'd2;

  localparam logic [1:0] M2R_ALU = 2'd0;
  localparam logic [1:0] M2R_MDR = 2'd1;
  localparam logic [1:0] M2R_PC  = 2'd2;

  localparam logic [1:0] ALUB_RT     = 2'd0;
  localparam logic [1:0] ALUB_FOUR   = 2'd1;
  localparam logic [1:0] ALUB_IMM    = 2'd2;
  localparam logic [1:0] ALUB_IMM_SH = 2'd3;

  localparam logic [1:0] TRAP_NONE    = 2'd0;
  localparam logic [1:0] TRAP_ILLEGAL = 2'd1;
  localparam logic [1:0] TRAP_BUS     = 2'd2;

  function automatic logic is_jr(logic [5:0] op, logic [5:0] fn);
    return (op == OP_RTYPE) && (fn == FN_JR);
  endfunction

  function automatic logic is_jump(logic [5:0] op, logic [5:0] fn);
    return (op == OP_J) || (op == OP_JAL) || is_jr(op, fn);
  endfunction

  function automatic logic is_branch(logic [5:0] op);
    return (op == OP_BEQ) || (op == OP_BNE);
  endfunction

  function automatic logic is_mem_op(logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// Combinational instruction decode: ALU operation, immediate extension mode and legality.
module mc_alu_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output alu_op_t    alu_op_o,
  output logic       sign_extend_o,
  output logic       legal_o
);

  always_comb begin
    alu_op_o      = ALU_ADDU;
    sign_extend_o = 1'b0;
    legal_o       = 1'b1;
    unique case (opcode_i)
      OP_RTYPE: begin
        unique case (funct_i)
          FN_SLL:  alu_op_o = ALU_SLL;
          FN_SRL:  alu_op_o = ALU_SRL;
          FN_SRA:  alu_op_o = ALU_SRA;
          FN_JR:   alu_op_o = ALU_ADDU;
          FN_ADDU: alu_op_o = ALU_ADDU;
          FN_SUBU: alu_op_o = ALU_SUBU;
          FN_AND:  alu_op_o = ALU_AND;
          FN_OR:   alu_op_o = ALU_OR;
          FN_XOR:  alu_op_o = ALU_XOR;
          FN_NOR:  alu_op_o = ALU_NOR;
          FN_SLT:  alu_op_o = ALU_SLT;
          FN_SLTU: alu_op_o = ALU_SLTU;
          default: legal_o = 1'b0;
        endcase
      end
      OP_J, OP_JAL: alu_op_o = ALU_ADDU;
      OP_BEQ, OP_BNE: alu_op_o = ALU_SUBU;
      OP_ADDIU, OP_LW, OP_SW: begin
        alu_op_o      = ALU_ADDU;
        sign_extend_o = 1'b1;
      end
      OP_SLTI: begin
        alu_op_o      = ALU_SLT;
        sign_extend_o = 1'b1;
      end
      OP_SLTIU: begin
        alu_op_o      = ALU_SLTU;
        sign_extend_o = 1'b1;
      end
      OP_ANDI: alu_op_o = ALU_AND;
      OP_ORI:  alu_op_o = ALU_OR;
      OP_XORI: alu_op_o = ALU_XOR;
      OP_LUI:  alu_op_o = ALU_LUI;
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: fetch/decode/exec/mem/writeback sequencing with memory wait
// states, bus timeout, illegal-instruction trap and a retired-instruction counter.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned ALUOP_W     = 4,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode_i,
  input  logic [5:0]         funct_i,
  input  logic               alu_zero_i,
  input  logic               mem_ready_i,
  output logic               mem_req_o,
  output logic               mem_we_o,
  output logic               iord_o,
  output logic               ir_write_o,
  output logic               pc_write_o,
  output logic [1:0]         pc_src_o,
  output logic               reg_write_o,
  output logic [1:0]         reg_dst_o,
  output logic [1:0]         mem_to_reg_o,
  output logic               alu_src_a_o,
  output logic [1:0]         alu_src_b_o,
  output logic               sign_extend_o,
  output logic [ALUOP_W-1:0] alu_op_o,
  output logic               retire_o,
  output logic [CNT_W-1:0]   instr_count_o,
  output logic               trap_o,
  output logic [1:0]         trap_cause_o
);

  localparam int unsigned WaitW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             trap_q, trap_d;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] cnt_q;
  logic             run_q;
  logic             expired;

  alu_op_t dec_alu_op;
  logic    dec_sign_extend;
  logic    dec_legal;

  mc_alu_dec u_alu_dec (
    .opcode_i      (opcode_i),
    .funct_i       (funct_i),
    .alu_op_o      (dec_alu_op),
    .sign_extend_o (dec_sign_extend),
    .legal_o       (dec_legal)
  );

  // The last permitted wait cycle; mem_ready in that same cycle still completes the access.
  assign expired = (MEM_TIMEOUT != 0) && (wait_q == WaitLast);

  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    trap_d  = trap_q;
    cause_d = cause_q;
    if (run_q) begin
      unique case (state_q)
        StFetch: begin
          if (mem_ready_i) begin
            state_d = StDecode;
          end else if (expired) begin
            state_d = StTrap;
            trap_d  = 1'b1;
            cause_d = TRAP_BUS;
          end else begin
            wait_d = wait_q + WaitW'(1);
          end
        end
        StDecode: begin
          if (!dec_legal) begin
            state_d = StTrap;
            trap_d  = 1'b1;
            cause_d = TRAP_ILLEGAL;
          end else if (is_jump(opcode_i, funct_i)) begin
            state_d = StFetch;
          end else begin
            state_d = StExec;
          end
        end
        StExec: begin
          if (is_branch(opcode_i))      state_d = StFetch;
          else if (is_mem_op(opcode_i)) state_d = StMem;
          else                          state_d = StWb;
        end
        StMem: begin
          if (mem_ready_i) begin
            state_d = (opcode_i == OP_SW) ? StFetch : StWb;
          end else if (expired) begin
            state_d = StTrap;
            trap_d  = 1'b1;
            cause_d = TRAP_BUS;
          end else begin
            wait_d = wait_q + WaitW'(1);
          end
        end
        StWb:    state_d = StFetch;
        StTrap:  state_d = StTrap;
        default: state_d = StFetch;
      endcase
    end
  end

  always_comb begin
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    iord_o        = 1'b0;
    ir_write_o    = 1'b0;
    pc_write_o    = 1'b0;
    pc_src_o      = PC_SRC_SEQ;
    reg_write_o   = 1'b0;
    reg_dst_o     = REG_DST_RT;
    mem_to_reg_o  = M2R_ALU;
    alu_src_a_o   = 1'b0;
    alu_src_b_o   = ALUB_RT;
    sign_extend_o = 1'b0;
    alu_op_o      = ALUOP_W'(ALU_ADDU);
    retire_o      = 1'b0;
    if (run_q) begin
      unique case (state_q)
        StFetch: begin
          mem_req_o = 1'b1;
          if (mem_ready_i) begin
            ir_write_o  = 1'b1;
            pc_write_o  = 1'b1;
            alu_src_b_o = ALUB_FOUR;
          end
        end
        StDecode: begin
          alu_src_b_o   = ALUB_IMM_SH;
          sign_extend_o = 1'b1;  // branch offsets are signed
          if (dec_legal && is_jump(opcode_i, funct_i)) begin
            pc_write_o = 1'b1;
            retire_o   = 1'b1;
            pc_src_o   = is_jr(opcode_i, funct_i) ? PC_SRC_JR : PC_SRC_JMP;
            if (opcode_i == OP_JAL) begin
              reg_write_o  = 1'b1;
              reg_dst_o    = REG_DST_RA;
              mem_to_reg_o = M2R_PC;
            end
          end
        end
        StExec: begin
          alu_src_a_o = 1'b1;
          alu_op_o    = ALUOP_W'(dec_alu_op);
          if (is_branch(opcode_i)) begin
            pc_src_o   = PC_SRC_BR;
            pc_write_o = (opcode_i == OP_BEQ) ? alu_zero_i : !alu_zero_i;
            retire_o   = 1'b1;
          end else if (opcode_i != OP_RTYPE) begin
            alu_src_b_o   = ALUB_IMM;
            sign_extend_o = dec_sign_extend;
          end
        end
        StMem: begin
          mem_req_o = 1'b1;
          iord_o    = 1'b1;
          mem_we_o  = (opcode_i == OP_SW);
          retire_o  = mem_ready_i && (opcode_i == OP_SW);
        end
        StWb: begin
          reg_write_o  = 1'b1;
          reg_dst_o    = (opcode_i == OP_RTYPE) ? REG_DST_RD : REG_DST_RT;
          mem_to_reg_o = (opcode_i == OP_LW) ? M2R_MDR : M2R_ALU;
          retire_o     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // run_q holds every output quiet until the first edge after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFetch;
      run_q   <= 1'b0;
      wait_q  <= '0;
      trap_q  <= 1'b0;
      cause_q <= TRAP_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      wait_q  <= wait_d;
      trap_q  <= trap_d;
      cause_q <= cause_d;
      if (retire_o) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign instr_count_o = cnt_q;
  assign trap_o        = trap_q;
  assign trap_cause_o  = cause_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized instruction-stream bench for mc_ctrl against a per-instruction trace model.
module tb_mc_ctrl;

  localparam int unsigned CntW    = 4;
  localparam int          Timeout = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [5:0]      opcode, funct;
  logic            alu_zero, mem_ready;
  logic            mem_req, mem_we, iord, ir_write, pc_write, reg_write, alu_src_a;
  logic            sign_extend, retire, trap;
  logic [1:0]      pc_src, reg_dst, mem_to_reg, alu_src_b, trap_cause;
  logic [3:0]      alu_op;
  logic [CntW-1:0] instr_count;

  int n_tests = 0;
  int n_fail  = 0;
  logic [CntW-1:0] cnt_model = '0;

  typedef struct packed {
    logic       mem_req, mem_we, iord, ir_write, pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic [1:0] reg_dst, mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       sign_extend;
    logic [3:0] alu_op;
    logic       retire, trap;
    logic [1:0] trap_cause;
  } outs_t;

  outs_t obs;
  assign obs = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write, reg_dst,
                mem_to_reg, alu_src_a, alu_src_b, sign_extend, alu_op, retire, trap, trap_cause};

  always #5 clk = ~clk;

  mc_ctrl #(
    .ALUOP_W     (4),
    .CNT_W       (CntW),
    .MEM_TIMEOUT (Timeout)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .opcode_i      (opcode),
    .funct_i       (funct),
    .alu_zero_i    (alu_zero),
    .mem_ready_i   (mem_ready),
    .mem_req_o     (mem_req),
    .mem_we_o      (mem_we),
    .iord_o        (iord),
    .ir_write_o    (ir_write),
    .pc_write_o    (pc_write),
    .pc_src_o      (pc_src),
    .reg_write_o   (reg_write),
    .reg_dst_o     (reg_dst),
    .mem_to_reg_o  (mem_to_reg),
    .alu_src_a_o   (alu_src_a),
    .alu_src_b_o   (alu_src_b),
    .sign_extend_o (sign_extend),
    .alu_op_o      (alu_op),
    .retire_o      (retire),
    .instr_count_o (instr_count),
    .trap_o        (trap),
    .trap_cause_o  (trap_cause)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Instruction-set view of the control unit, independent of any state encoding.
  function automatic logic legal(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00: return fn inside {6'h00, 6'h02, 6'h03, 6'h08, 6'h21, 6'h23, 6'h24, 6'h25,
                               6'h26, 6'h27, 6'h2A, 6'h2B};
      6'h02, 6'h03, 6'h04, 6'h05, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
      6'h23, 6'h2B: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] alu_exp(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00) begin
      case (fn)
        6'h00: return 4'd8;   // sll
        6'h02: return 4'd9;   // srl
        6'h03: return 4'd10;  // sra
        6'h23: return 4'd1;
        6'h24: return 4'd2;
        6'h25: return 4'd3;
        6'h26: return 4'd4;
        6'h27: return 4'd5;
        6'h2A: return 4'd6;
        6'h2B: return 4'd7;
        default: return 4'd0;
      endcase
    end
    case (op)
      6'h04, 6'h05: return 4'd1;
      6'h0A: return 4'd6;
      6'h0B: return 4'd7;
      6'h0C: return 4'd2;
      6'h0D: return 4'd3;
      6'h0E: return 4'd4;
      6'h0F: return 4'd11;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic is_jmp(input logic [5:0] op, input logic [5:0] fn);
    return op == 6'h02 || op == 6'h03 || (op == 6'h00 && fn == 6'h08);
  endfunction

  function automatic outs_t v_fetch(input logic done);
    outs_t e = '0;
    e.mem_req = 1'b1;
    if (done) begin
      e.ir_write  = 1'b1;
      e.pc_write  = 1'b1;
      e.alu_src_b = 2'd1;
    end
    return e;
  endfunction

  function automatic outs_t v_decode(input logic [5:0] op, input logic [5:0] fn);
    outs_t e = '0;
    e.alu_src_b   = 2'd3;
    e.sign_extend = 1'b1;
    if (op == 6'h02 || op == 6'h03) begin
      e.pc_write = 1'b1;
      e.pc_src   = 2'd2;
      e.retire   = 1'b1;
      if (op == 6'h03) begin
        e.reg_write  = 1'b1;
        e.reg_dst    = 2'd2;
        e.mem_to_reg = 2'd2;
      end
    end else if (op == 6'h00 && fn == 6'h08) begin
      e.pc_write = 1'b1;
      e.pc_src   = 2'd3;
      e.retire   = 1'b1;
    end
    return e;
  endfunction

  function automatic outs_t v_exec(input logic [5:0] op, input logic [5:0] fn, input logic z);
    outs_t e = '0;
    e.alu_src_a = 1'b1;
    e.alu_op    = alu_exp(op, fn);
    if (op == 6'h04 || op == 6'h05) begin
      e.pc_src   = 2'd1;
      e.pc_write = (op == 6'h04) ? z : !z;
      e.retire   = 1'b1;
    end else if (op != 6'h00) begin
      e.alu_src_b   = 2'd2;
      e.sign_extend = op inside {6'h09, 6'h0A, 6'h0B, 6'h23, 6'h2B};
    end
    return e;
  endfunction

  function automatic outs_t v_mem(input logic [5:0] op, input logic done);
    outs_t e = '0;
    e.mem_req = 1'b1;
    e.iord    = 1'b1;
    e.mem_we  = (op == 6'h2B);
    e.retire  = done && op == 6'h2B;
    return e;
  endfunction

  function automatic outs_t v_wb(input logic [5:0] op);
    outs_t e = '0;
    e.reg_write  = 1'b1;
    e.reg_dst    = (op == 6'h00) ? 2'd1 : 2'd0;
    e.mem_to_reg = (op == 6'h23) ? 2'd1 : 2'd0;
    e.retire     = 1'b1;
    return e;
  endfunction

  // One clock cycle: drive, sample mid-cycle, advance past the edge, check the counter.
  task automatic cyc(input string tag, input outs_t e, input logic mr, input logic z);
    mem_ready = mr;
    alu_zero  = z;
    @(negedge clk);
    check(tag, 32'(obs), 32'(e));
    @(posedge clk);
    #1;
    if (e.retire) cnt_model = cnt_model + 1'b1;
    check({tag, "_cnt"}, 32'(instr_count), 32'(cnt_model));
  endtask

  task automatic trap_hold(input logic [1:0] cause, input int n);
    outs_t e = '0;
    e.trap       = 1'b1;
    e.trap_cause = cause;
    for (int i = 0; i < n; i++) begin
      opcode = 6'($urandom);
      cyc("trap", e, 1'($urandom), 1'($urandom));
    end
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_outs", 32'(obs), 32'h0);
    check("rst_cnt", 32'(instr_count), 32'h0);
    cnt_model = '0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // fw/mw are wait cycles per access; a value equal to Timeout means the access times out.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fw,
                           input int mw, input logic z, output logic trapped);
    trapped = 1'b0;
    for (int i = 0; i < fw; i++) begin
      opcode = 6'($urandom);
      funct  = 6'($urandom);
      cyc("fetch_wait", v_fetch(1'b0), 1'b0, 1'($urandom));
    end
    if (fw >= Timeout) begin
      trap_hold(2'd2, 3);
      trapped = 1'b1;
      return;
    end
    cyc("fetch", v_fetch(1'b1), 1'b1, 1'($urandom));
    opcode = op;
    funct  = fn;
    cyc("decode", v_decode(op, fn), 1'($urandom), 1'($urandom));
    if (!legal(op, fn)) begin
      trap_hold(2'd1, 3);
      trapped = 1'b1;
      return;
    end
    if (is_jmp(op, fn)) return;
    cyc("exec", v_exec(op, fn, z), 1'($urandom), z);
    if (op == 6'h04 || op == 6'h05) return;
    if (op == 6'h23 || op == 6'h2B) begin
      for (int i = 0; i < mw; i++) cyc("mem_wait", v_mem(op, 1'b0), 1'b0, 1'($urandom));
      if (mw >= Timeout) begin
        trap_hold(2'd2, 3);
        trapped = 1'b1;
        return;
      end
      cyc("mem", v_mem(op, 1'b1), 1'b1, 1'($urandom));
      if (op == 6'h2B) return;
    end
    cyc("wb", v_wb(op), 1'($urandom), 1'($urandom));
  endtask

  logic [5:0] op_tab [14];
  logic [5:0] fn_tab [12];

  initial begin
    logic       tr;
    logic [5:0] op, fn;
    int         fw, mw;
    op_tab = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D,
               6'h0E, 6'h0F, 6'h23, 6'h2B};
    fn_tab = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
               6'h2A, 6'h2B};
    rst = 1'b1;
    opcode = '0;
    funct = '0;
    alu_zero = 1'b0;
    mem_ready = 1'b0;
    #3;
    check("reset_outs", 32'(obs), 32'h0);
    check("reset_cnt", 32'(instr_count), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    run_instr(6'h00, 6'h21, 0, 0, 1'b0, tr);            // ADDU
    check("addu_count", 32'(instr_count), 32'd1);
    run_instr(6'h23, 6'h00, 0, 3, 1'b0, tr);            // LW, ready on the last allowed cycle
    run_instr(6'h04, 6'h00, 0, 0, 1'b1, tr);            // BEQ taken
    run_instr(6'h04, 6'h00, 1, 0, 1'b0, tr);            // BEQ not taken
    run_instr(6'h05, 6'h00, 0, 0, 1'b1, tr);            // BNE not taken
    run_instr(6'h05, 6'h00, 0, 0, 1'b0, tr);            // BNE taken
    run_instr(6'h03, 6'h00, 0, 0, 1'b0, tr);            // JAL
    run_instr(6'h00, 6'h08, 2, 0, 1'b0, tr);            // JR
    run_instr(6'h2B, 6'h00, 3, 2, 1'b0, tr);            // SW with waits

    run_instr(6'h3F, 6'h00, 0, 0, 1'b0, tr);            // illegal opcode
    trap_hold(2'd1, 20);
    do_reset();
    run_instr(6'h00, 6'h3F, 0, 0, 1'b0, tr);            // illegal funct
    do_reset();
    run_instr(6'h0D, 6'h00, Timeout, 0, 1'b0, tr);      // fetch timeout
    do_reset();
    run_instr(6'h23, 6'h00, 0, Timeout, 1'b0, tr);      // memory timeout
    do_reset();

    for (int k = 0; k < 300; k++) begin
      op = op_tab[$urandom_range(0, 13)];
      fn = (op == 6'h00) ? fn_tab[$urandom_range(0, 11)] : 6'($urandom);
      if ($urandom_range(0, 19) == 0) op = 6'($urandom);
      fw = ($urandom_range(0, 39) == 0) ? Timeout : int'($urandom_range(0, 3));
      mw = ($urandom_range(0, 39) == 0) ? Timeout : int'($urandom_range(0, 3));
      run_instr(op, fn, fw, mw, 1'($urandom), tr);
      if (tr) do_reset();
    end

    // Reset asserted in the middle of a load's memory access.
    run_instr(6'h00, 6'h25, 0, 0, 1'b0, tr);
    cyc("fetch", v_fetch(1'b1), 1'b1, 1'b0);
    opcode = 6'h23;
    funct  = 6'h00;
    cyc("decode", v_decode(6'h23, 6'h00), 1'b0, 1'b0);
    cyc("exec", v_exec(6'h23, 6'h00, 1'b0), 1'b0, 1'b0);
    cyc("mem_wait", v_mem(6'h23, 1'b0), 1'b0, 1'b0);
    do_reset();
    run_instr(6'h00, 6'h21, 0, 0, 1'b0, tr);
    check("post_rst_count", 32'(instr_count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle MIPS control unit: a Moore FSM that sequences fetch, decode, execute, memory and writeback over shared datapath resources.
- Supersedes the purely combinational single-cycle decoder.
- Adds a memory handshake with wait states, a bus timeout, illegal-opcode trapping and a retired-instruction counter.
- Sits between the instruction register (which supplies opcode/funct) and the multi-cycle datapath muxes and enables.

Parameters:
- ALUOP_W, 4, width of alu_op; encodings come from the shared ALU constants.
- CNT_W, 32, width of the retired-instruction counter.
- MEM_TIMEOUT, 0, maximum wait cycles per memory access; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- opcode  in  6  IR[31:26]; valid from DECODE onward
- funct  in  6  IR[5:0]
- alu_zero  in  1  ALU zero flag; sampled in EXEC for branches
- mem_ready  in  1  memory access complete this cycle
- mem_req  out  1  memory request; held until mem_ready
- mem_we  out  1  write when mem_req
- iord  out  1  memory address select: 0 = PC, 1 = ALU-out register
- ir_write  out  1  load IR
- pc_write  out  1  load PC
- pc_src  out  2  0 = PC+4, 1 = branch target, 2 = jump target, 3 = rs (JR)
- reg_write  out  1  register-file write
- reg_dst  out  2  0 = rt, 1 = rd, 2 = $31
- mem_to_reg  out  2  0 = ALU-out, 1 = MDR, 2 = PC (link)
- alu_src_a  out  1  0 = PC, 1 = rs
- alu_src_b  out  2  0 = rt, 1 = 4, 2 = immediate, 3 = immediate<<2
- sign_extend  out  1  immediate extension mode
- alu_op  out  ALUOP_W  ALU operation
- retire  out  1  one-cycle pulse when an instruction completes
- instr_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W
- trap  out  1  sticky; set on illegal opcode/funct or bus timeout
- trap_cause  out  2  1 = illegal instruction, 2 = bus timeout

Behaviour:
- Reset: asynchronous and active-high. Asserting rst at any point, including mid-access, forces state to FETCH and drives every output to 0, instr_count to 0 and trap to 0. On the first clock edge after rst deasserts, the FSM is in FETCH.
- Outputs are registered state decodes (Moore); alu_op additionally depends on opcode/funct in EXEC.
- States and transitions:
  - FETCH: mem_req=1, iord=0. When mem_ready=1: ir_write=1, pc_write=1, pc_src=0, alu_src_a=0, alu_src_b=1, alu_op=ADDU, then go to DECODE. Otherwise stay in FETCH.
  - DECODE: computes branch target (alu_src_a=0, alu_src_b=3, alu_op=ADDU).
    - J: pc_write=1, pc_src=2, retire, go to FETCH.
    - JAL: as J, plus reg_write=1, reg_dst=2, mem_to_reg=2.
    - R-type JR: pc_write=1, pc_src=3, retire.
    - Unknown opcode or unknown R-type funct: go to TRAP.
    - All others: go to EXEC.
  - EXEC:
    - R-type: alu_src_a=1, alu_src_b=0, alu_op from funct.
    - ADDIU/SLTI/SLTIU/LW/SW: alu_src_b=2, sign_extend=1.
    - ANDI/ORI/XORI/LUI: alu_src_b=2, sign_extend=0.
    - BEQ/BNE: alu_op=SUBU, alu_src_a=1, alu_src_b=0. pc_write = alu_zero for BEQ or !alu_zero for BNE, with pc_src=1. Retire, go to FETCH.
    - LW/SW go to MEM; all others go to WB.
  - MEM: mem_req=1, iord=1, mem_we=1 for SW. Hold until mem_ready. SW retires and goes to FETCH; LW goes to WB.
  - WB: reg_write=1. R-type: reg_dst=1, mem_to_reg=0. I-type: reg_dst=0, mem_to_reg=0. LW: reg_dst=0, mem_to_reg=1. Retire, go to FETCH.
  - TRAP: absorbing state. All outputs 0 except trap and trap_cause. Exit only by reset.
- Latency with zero-wait memory (mem_ready=1 on the first request cycle):
  - J/JAL/JR: 2 cycles.
  - Branch: 3 cycles.
  - R-type, I-type ALU and SW: 4 cycles.
  - LW: 5 cycles.
  - Each wait cycle adds 1 cycle per access.
- Timeout: a wait counter clears on entering FETCH or MEM. If MEM_TIMEOUT>0 and MEM_TIMEOUT cycles elapse with mem_ready=0, go to TRAP with trap_cause=2 and deassert mem_req. mem_ready arriving in the same cycle the counter expires wins: the access completes with no trap.
- instr_count increments on each retire pulse; a retire at all-ones wraps to 0.
- mem_ready outside FETCH/MEM is ignored.

Decomposition:
- Shared package (existing global include): opcode/funct codes, ALU_* encodings, and the new constants for state encoding, pc_src, reg_dst, mem_to_reg, alu_src_b and trap_cause.
- One sub-module: mc_alu_dec, a combinational map from (opcode, funct) to (alu_op, sign_extend, legal), used in DECODE and EXEC.

Test Plan:
- ADDU (op 0x00, funct 0x21), mem_ready always 1 -> states FETCH, DECODE, EXEC, WB; reg_write with reg_dst=1 in cycle 4; retire=1 once; instr_count=1.
- LW (0x23) with mem_ready delayed 3 cycles in MEM -> mem_req high 4 cycles with iord=1; WB has mem_to_reg=1; 8 cycles total.
- BEQ (0x04) run once with alu_zero=1 and once with alu_zero=0 -> pc_write=1 with pc_src=1 in EXEC only when zero; BNE (0x05) gives the inverse.
- JAL (0x03) -> in DECODE: pc_write=1, pc_src=2, reg_write=1, reg_dst=2, mem_to_reg=2; 2 cycles.
- Opcode 0x3F -> TRAP with trap=1, trap_cause=1, all enables 0 for 20 cycles; rst pulse returns to FETCH with mem_req=1.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> TRAP with cause 2 after 4 cycles. Separately, assert rst mid-MEM -> outputs 0 immediately (asynchronous) and instr_count=0.
